// File: rtl/dmem_lsu_port.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lsu_port
// Purpose  : LSU-side controller for a 16x32 1W/1R SRAM. Handles byte-lane
//            formatting, load extraction and post-reset zero fill.
// Revision : 1.0  initial release
// ============================================================================
module dmem_lsu_port #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_WMASKS = 4,
    parameter int TAG_WIDTH  = 4,
    parameter int RESP_DEPTH = 4,
    parameter int INIT_EN    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDR_WIDTH+1:0] ld_addr,
    input  logic [1:0]            ld_size,
    input  logic                  ld_signed,
    input  logic [TAG_WIDTH-1:0]  ld_tag,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [ADDR_WIDTH+1:0] st_addr,
    input  logic [1:0]            st_size,
    input  logic [DATA_WIDTH-1:0] st_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [TAG_WIDTH-1:0]  resp_tag,
    output logic                  resp_err,
    output logic                  st_err,
    output logic                  init_done,
    output logic                  mem_csb0,
    output logic [NUM_WMASKS-1:0] mem_wmask0,
    output logic [ADDR_WIDTH-1:0] mem_addr0,
    output logic [DATA_WIDTH-1:0] mem_din0,
    output logic                  mem_csb1,
    output logic [ADDR_WIDTH-1:0] mem_addr1,
    input  logic [DATA_WIDTH-1:0] mem_dout1
);
    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int FCNT_W = $clog2(RESP_DEPTH + 1);
    localparam int OUT_W = $clog2(RESP_DEPTH + 3);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = '1;

    typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  init_cnt_q, init_cnt_d;
    logic                   init_done_q;
    logic                   csb0_q, csb0_d, csb1_q, csb1_d;
    logic [NUM_WMASKS-1:0]  wmask0_q, wmask0_d;
    logic [ADDR_WIDTH-1:0]  addr0_q, addr0_d, addr1_q, addr1_d;
    logic [DATA_WIDTH-1:0]  din0_q, din0_d;
    logic                   st_err_q, st_err_d;

    logic                   s1_valid_q, s1_err_q, s1_signed_q;
    logic [1:0]             s1_off_q, s1_size_q;
    logic [TAG_WIDTH-1:0]   s1_tag_q;
    logic                   s2_valid_q, s2_err_q, s2_signed_q;
    logic [1:0]             s2_off_q, s2_size_q;
    logic [TAG_WIDTH-1:0]   s2_tag_q;

    logic [DATA_WIDTH-1:0]  fifo_data_q [RESP_DEPTH];
    logic [TAG_WIDTH-1:0]   fifo_tag_q  [RESP_DEPTH];
    logic                   fifo_err_q  [RESP_DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q, wr_ptr_q;
    logic [FCNT_W-1:0]      fifo_cnt_q;

    logic                   ld_ok, st_ok, ld_fire, st_fire, conflict, push, pop;
    logic [OUT_W-1:0]       outstanding;
    logic [NUM_WMASKS-1:0]  st_wmask;
    logic [DATA_WIDTH-1:0]  st_lane, ld_result;
    logic [7:0]             ld_byte;
    logic [15:0]            ld_half;

    function automatic logic size_ok(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   size_ok = 1'b1;
            2'b01:   size_ok = ~off[0];
            2'b10:   size_ok = (off == 2'b00);
            default: size_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign ld_ok       = size_ok(ld_size, ld_addr[1:0]);
    assign st_ok       = size_ok(st_size, st_addr[1:0]);
    assign conflict    = ld_valid && st_valid
                         && (ld_addr[ADDR_WIDTH+1:2] == st_addr[ADDR_WIDTH+1:2]);
    // A response popped this cycle does not free its credit until next cycle.
    assign outstanding = OUT_W'(s1_valid_q) + OUT_W'(s2_valid_q) + OUT_W'(fifo_cnt_q);
    assign ld_ready    = init_done_q && (outstanding < OUT_W'(RESP_DEPTH)) && !conflict;
    assign st_ready    = init_done_q;
    assign ld_fire     = ld_valid && ld_ready;
    assign st_fire     = st_valid && st_ready;

    always_comb begin
        st_wmask = '1;
        st_lane  = st_data;
        case (st_size)
            2'b00: begin
                st_wmask = NUM_WMASKS'(1) << st_addr[1:0];
                st_lane  = {4{st_data[7:0]}};
            end
            2'b01: begin
                st_wmask = st_addr[1] ? NUM_WMASKS'(4'b1100) : NUM_WMASKS'(4'b0011);
                st_lane  = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        csb0_d     = 1'b1;
        wmask0_d   = wmask0_q;
        addr0_d    = addr0_q;
        din0_d     = din0_q;
        csb1_d     = 1'b1;
        addr1_d    = addr1_q;
        st_err_d   = 1'b0;
        case (state_q)
            ST_INIT: begin
                csb0_d     = 1'b0;
                wmask0_d   = '1;
                addr0_d    = init_cnt_q;
                din0_d     = '0;
                init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
                if (init_cnt_q == LAST_WORD) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (st_fire) begin
                    if (st_ok) begin
                        csb0_d   = 1'b0;
                        wmask0_d = st_wmask;
                        addr0_d  = st_addr[ADDR_WIDTH+1:2];
                        din0_d   = st_lane;
                    end else begin
                        st_err_d = 1'b1;
                    end
                end
                if (ld_fire && ld_ok) begin
                    csb1_d  = 1'b0;
                    addr1_d = ld_addr[ADDR_WIDTH+1:2];
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            csb0_q      <= 1'b1;
            wmask0_q    <= '0;
            addr0_q     <= '0;
            din0_q      <= '0;
            csb1_q      <= 1'b1;
            addr1_q     <= '0;
            st_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= (state_q == ST_RUN);
            csb0_q      <= csb0_d;
            wmask0_q    <= wmask0_d;
            addr0_q     <= addr0_d;
            din0_q      <= din0_d;
            csb1_q      <= csb1_d;
            addr1_q     <= addr1_d;
            st_err_q    <= st_err_d;
        end
    end

    // Stage 1 covers the SRAM address phase, stage 2 the data phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= ld_fire;
            s2_valid_q <= s1_valid_q;
        end
        s1_err_q    <= ~ld_ok;
        s1_signed_q <= ld_signed;
        s1_off_q    <= ld_addr[1:0];
        s1_size_q   <= ld_size;
        s1_tag_q    <= ld_tag;
        s2_err_q    <= s1_err_q;
        s2_signed_q <= s1_signed_q;
        s2_off_q    <= s1_off_q;
        s2_size_q   <= s1_size_q;
        s2_tag_q    <= s1_tag_q;
    end

    always_comb begin
        ld_byte = mem_dout1[{s2_off_q, 3'b000} +: 8];
        ld_half = s2_off_q[1] ? mem_dout1[31:16] : mem_dout1[15:0];
        case (s2_size_q)
            2'b00:   ld_result = {{24{s2_signed_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_result = {{16{s2_signed_q & ld_half[15]}}, ld_half};
            default: ld_result = mem_dout1;
        endcase
        if (s2_err_q) begin
            ld_result = '0;
        end
    end

    assign push = s2_valid_q;
    assign pop  = resp_valid && resp_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= ld_result;
            fifo_tag_q[wr_ptr_q]  <= s2_tag_q;
            fifo_err_q[wr_ptr_q]  <= s2_err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + FCNT_W'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - FCNT_W'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    assign resp_valid = (fifo_cnt_q != '0);
    assign resp_data  = fifo_data_q[rd_ptr_q];
    assign resp_tag   = fifo_tag_q[rd_ptr_q];
    assign resp_err   = fifo_err_q[rd_ptr_q];
    assign st_err     = st_err_q;
    assign init_done  = init_done_q;
    assign mem_csb0   = csb0_q;
    assign mem_wmask0 = wmask0_q;
    assign mem_addr0  = addr0_q;
    assign mem_din0   = din0_q;
    assign mem_csb1   = csb1_q;
    assign mem_addr1  = addr1_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_lsu_port
// Purpose  : Directed self-checking bench for dmem_lsu_port with an SRAM model.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_lsu_port;
    logic        clk;
    logic        rst;
    logic        ld_valid, ld_ready, ld_signed;
    logic [5:0]  ld_addr;
    logic [1:0]  ld_size;
    logic [3:0]  ld_tag;
    logic        st_valid, st_ready;
    logic [5:0]  st_addr;
    logic [1:0]  st_size;
    logic [31:0] st_data;
    logic        resp_valid, resp_ready, resp_err, st_err, init_done;
    logic [31:0] resp_data;
    logic [3:0]  resp_tag;
    logic        mem_csb0, mem_csb1;
    logic [3:0]  mem_wmask0, mem_addr0, mem_addr1;
    logic [31:0] mem_din0, mem_dout1;

    int n_vec = 0;
    int n_miscmp = 0;

    dmem_lsu_port dut (
        .clk        (clk),
        .rst        (rst),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_size    (ld_size),
        .ld_signed  (ld_signed),
        .ld_tag     (ld_tag),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_addr    (st_addr),
        .st_size    (st_size),
        .st_data    (st_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .resp_err   (resp_err),
        .st_err     (st_err),
        .init_done  (init_done),
        .mem_csb0   (mem_csb0),
        .mem_wmask0 (mem_wmask0),
        .mem_addr0  (mem_addr0),
        .mem_din0   (mem_din0),
        .mem_csb1   (mem_csb1),
        .mem_addr1  (mem_addr1),
        .mem_dout1  (mem_dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: controls sampled at posedge, write performed at the following negedge.
    logic [31:0] sram [16];
    logic        s_csb0;
    logic [3:0]  s_wm, s_a0;
    logic [31:0] s_din, wr_word;
    bit          seeded = 1'b0;

    always @(posedge clk) begin
        s_csb0 <= mem_csb0;
        s_wm   <= mem_wmask0;
        s_a0   <= mem_addr0;
        s_din  <= mem_din0;
        if (mem_csb1 === 1'b0) mem_dout1 <= sram[mem_addr1];
    end

    always @(negedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 16; i++) sram[i] <= 32'hC0DE0000 + 32'(i);
            seeded <= 1'b1;
        end else if (s_csb0 === 1'b0) begin
            wr_word = sram[s_a0];
            for (int b = 0; b < 4; b++) if (s_wm[b]) wr_word[8*b +: 8] = s_din[8*b +: 8];
            sram[s_a0] <= wr_word;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_check(input string nm, input logic [5:0] a, input logic [1:0] sz,
                              input logic sg, input logic [3:0] tg,
                              input logic [31:0] exp_d, input logic exp_e);
        int n;
        ld_valid = 1'b1; ld_addr = a; ld_size = sz; ld_signed = sg; ld_tag = tg;
        #1;
        n = 0;
        while (!ld_ready && n < 50) begin
            tick();
            n++;
        end
        check_val({nm, "_rdy"}, 64'(ld_ready), 64'(1));
        tick();
        ld_valid = 1'b0;
        check_val({nm, "_e0"}, {mem_csb1, resp_valid}, {exp_e, 1'b0});
        tick();
        check_val({nm, "_e1"}, 64'(resp_valid), 64'(0));
        tick();
        check_val({nm, "_resp"}, {resp_valid, resp_err, resp_tag, resp_data},
                  {1'b1, exp_e, tg, exp_d});
        tick();
    endtask

    task automatic store_check(input string nm, input logic [5:0] a, input logic [1:0] sz,
                               input logic [31:0] d, input logic [3:0] exp_wm,
                               input logic [31:0] exp_din, input logic exp_e);
        st_valid = 1'b1; st_addr = a; st_size = sz; st_data = d;
        #1;
        check_val({nm, "_rdy"}, 64'(st_ready), 64'(1));
        tick();
        st_valid = 1'b0;
        if (exp_e)
            check_val({nm, "_drop"}, {mem_csb0, st_err}, 2'b11);
        else
            check_val({nm, "_bus"}, {st_err, mem_csb0, mem_wmask0, mem_addr0, mem_din0},
                      {1'b0, 1'b0, exp_wm, a[5:2], exp_din});
        tick();
        check_val({nm, "_idle"}, {mem_csb0, st_err}, 2'b10);
    endtask

    logic [31:0] exp_w [4];
    int          acc, got, saw, found;
    logic        rdy;
    logic [3:0]  first_a;

    initial begin
        exp_w[0] = 32'hCAFEF00D; exp_w[1] = 32'h0; exp_w[2] = 32'hDEAD5AEF; exp_w[3] = 32'h12345678;
        rst = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_size = '0; ld_signed = 1'b0; ld_tag = '0;
        st_valid = 1'b0; st_addr = '0; st_size = '0; st_data = '0; resp_ready = 1'b1;
        repeat (3) tick();
        check_val("reset", {mem_csb0, mem_csb1, mem_wmask0, mem_addr0, mem_addr1, mem_din0,
                            resp_valid, st_err, init_done, ld_ready, st_ready},
                  {1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 32'h0, 5'b00000});
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            check_val("init_wr", {ld_ready, st_ready, init_done, mem_csb0, mem_wmask0, mem_addr0, mem_din0},
                      {4'b0000, 4'hF, 4'(i), 32'h0});
        end
        tick();
        check_val("init_done", {init_done, mem_csb0, ld_ready, st_ready}, 4'b1111);

        load_check("ld_cleared", 6'h3C, 2'b10, 1'b0, 4'h1, 32'h00000000, 1'b0);
        store_check("st_word", 6'h08, 2'b10, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b0);
        load_check("ld_sbyte", 6'h0B, 2'b00, 1'b1, 4'h2, 32'hFFFFFFDE, 1'b0);
        load_check("ld_uhalf", 6'h08, 2'b01, 1'b0, 4'h3, 32'h0000BEEF, 1'b0);
        store_check("st_byte", 6'h09, 2'b00, 32'h0000005A, 4'b0010, 32'h5A5A5A5A, 1'b0);
        load_check("ld_word", 6'h08, 2'b10, 1'b0, 4'h4, 32'hDEAD5AEF, 1'b0);

        // Same-word load and store in one cycle.
        ld_valid = 1'b1; ld_addr = 6'h0C; ld_size = 2'b10; ld_signed = 1'b0; ld_tag = 4'h5;
        st_valid = 1'b1; st_addr = 6'h0C; st_size = 2'b10; st_data = 32'h12345678;
        #1;
        check_val("conf_rdy", {ld_ready, st_ready}, 2'b01);
        tick();
        st_valid = 1'b0;
        check_val("conf_bus", {mem_csb0, mem_csb1, mem_addr0}, {1'b0, 1'b1, 4'h3});
        load_check("ld_after_conf", 6'h0C, 2'b10, 1'b0, 4'h5, 32'h12345678, 1'b0);

        // Different words in one cycle.
        ld_valid = 1'b1; ld_addr = 6'h0C; ld_size = 2'b10; ld_tag = 4'h6;
        st_valid = 1'b1; st_addr = 6'h00; st_size = 2'b10; st_data = 32'hCAFEF00D;
        #1;
        check_val("dual_rdy", {ld_ready, st_ready}, 2'b11);
        tick();
        ld_valid = 1'b0; st_valid = 1'b0;
        check_val("dual_bus", {mem_csb0, mem_csb1, mem_addr0, mem_addr1, mem_wmask0},
                  {1'b0, 1'b0, 4'h0, 4'h3, 4'hF});
        tick();
        tick();
        check_val("dual_resp", {resp_valid, resp_tag, resp_data}, {1'b1, 4'h6, 32'h12345678});
        tick();

        // Backpressure: credits run out after RESP_DEPTH loads.
        resp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            ld_valid = 1'b1; ld_addr = 6'(((acc % 4) * 4)); ld_size = 2'b10; ld_tag = 4'(acc);
            #1;
            rdy = ld_ready;
            tick();
            if (rdy) acc++;
        end
        #1;
        check_val("bp_accepted", {32'(acc), 31'h0, ld_ready}, {32'd4, 32'd0});
        check_val("bp_head", {resp_valid, resp_tag}, {1'b1, 4'h0});
        resp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            ld_valid = (acc < 6); ld_addr = 6'(((acc % 4) * 4)); ld_tag = 4'(acc);
            #1;
            rdy = ld_ready && ld_valid;
            if (resp_valid) begin
                check_val("bp_order", {resp_err, resp_tag, resp_data}, {1'b0, 4'(got), exp_w[got % 4]});
                got++;
            end
            tick();
            if (rdy) acc++;
        end
        ld_valid = 1'b0;
        check_val("bp_drained", 64'(got), 64'd6);

        load_check("ld_mis", 6'h05, 2'b01, 1'b0, 4'h7, 32'h0, 1'b1);
        store_check("st_mis", 6'h06, 2'b10, 32'h11111111, 4'h0, 32'h0, 1'b1);

        // Reset with two loads in flight.
        ld_valid = 1'b1; ld_addr = 6'h08; ld_size = 2'b10; ld_tag = 4'h9;
        #1;
        check_val("rst_ld0_rdy", 64'(ld_ready), 64'(1));
        tick();
        ld_tag = 4'hA;
        #1;
        check_val("rst_ld1_rdy", 64'(ld_ready), 64'(1));
        tick();
        ld_valid = 1'b0; rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        saw = 0; found = 0; first_a = 4'hF;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (resp_valid) saw++;
            if (found == 0 && mem_csb0 == 1'b0) begin
                found = 1;
                first_a = mem_addr0;
            end
        end
        check_val("rst_no_resp", 64'(saw), 64'd0);
        check_val("rst_init_restart", {32'(found), 28'h0, first_a}, {32'd1, 32'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end
endmodule
`default_nettype wire
